// File: rtl/cpu_control_pkg.sv
// Shared opcode, ALU-control and control-bundle definitions for the control pipeline.
package cpu_control_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_MOVI = 4'd4,
        OP_ADDI = 4'd5,
        OP_LDR  = 4'd6,
        OP_STR  = 4'd7,
        OP_B    = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10,
        OP_BLT  = 4'd11,
        OP_CMP  = 4'd12,
        OP_RS13 = 4'd13,
        OP_RS14 = 4'd14,
        OP_NOP  = 4'd15
    } opcodeT;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_PASS = 3'b100
    } aluCtlT;

    typedef enum logic [1:0] {
        COND_AL = 2'd0,
        COND_EQ = 2'd1,
        COND_NE = 2'd2,
        COND_LT = 2'd3
    } condT;

    // Bit positions inside the {N,Z,V,C} flag register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef struct packed {
        logic   valid;
        aluCtlT aluCtl;
        logic   data2Sel;
        logic   memWrite;
        logic   memToReg;
        logic   regWrite;
        logic   branch;
        condT   cond;
        logic   setFlags;
    } ctlBundleT;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode -> control bundle decode for the Decode stage.
module control_decoder
    import cpu_control_pkg::*;
#(
    parameter int OPCODEWIDTH = 4
) (
    input  logic [OPCODEWIDTH-1:0] opcode,
    output ctlBundleT              ctl
);

    logic upperClear;

    // Opcodes wider than four bits with any upper bit set fall through as NOP
    assign upperClear = ((opcode >> 4) == '0);

    always_comb begin
        ctl        = '0;
        ctl.aluCtl = ALU_ADD;
        ctl.cond   = COND_AL;
        if (upperClear) begin
            case (opcodeT'(opcode[3:0]))
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    ctl.valid    = 1'b1;
                    ctl.regWrite = 1'b1;
                    ctl.aluCtl   = aluCtlT'({1'b0, opcode[1:0]});
                    ctl.setFlags = (opcode[3:0] == OP_SUB);
                end
                OP_MOVI, OP_ADDI, OP_LDR: begin
                    ctl.valid    = 1'b1;
                    ctl.regWrite = 1'b1;
                    ctl.data2Sel = 1'b1;
                    ctl.aluCtl   = (opcode[3:0] == OP_MOVI) ? ALU_PASS : ALU_ADD;
                    ctl.memToReg = (opcode[3:0] == OP_LDR);
                end
                OP_STR: begin
                    ctl.valid    = 1'b1;
                    ctl.data2Sel = 1'b1;
                    ctl.memWrite = 1'b1;
                end
                OP_B, OP_BEQ, OP_BNE, OP_BLT: begin
                    ctl.valid    = 1'b1;
                    ctl.data2Sel = 1'b1;
                    ctl.branch   = 1'b1;
                    ctl.cond     = condT'(opcode[1:0]);
                end
                OP_CMP: begin
                    ctl.valid    = 1'b1;
                    ctl.aluCtl   = ALU_SUB;
                    ctl.setFlags = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Four-stage control path: decodes in D, carries the control bundle through E, M and WB,
// resolves branches in E against the flag register and redirects the PC from WB.
module control_pipeline
    import cpu_control_pkg::*;
#(
    parameter int OPCODEWIDTH = 4,
    parameter int COUNTWIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OPCODEWIDTH-1:0] opcodeD,
    input  logic                   N,
    input  logic                   Z,
    input  logic                   V,
    input  logic                   C,
    output logic                   obtainPCAsR1D,
    output logic                   data2SelectorE,
    output logic [2:0]             aluControlE,
    output logic                   writeDataEnableM,
    output logic                   resultSelectorWB,
    output logic                   writeEnableD,
    output logic                   PCSelectorF,
    output logic [COUNTWIDTH-1:0]  retiredCount
);

    ctlBundleT ctlD, slotE, slotM, slotWB;
    ctlBundleT nextE, nextM, nextWB;
    logic      takenM, takenWB;
    logic [3:0] flags;
    logic      killD, condMet, takenE, redirect;
    logic      unusedCtl;

    control_decoder #(.OPCODEWIDTH(OPCODEWIDTH)) decoder (
        .opcode (opcodeD),
        .ctl    (ctlD)
    );

    always_comb begin
        condMet = 1'b0;
        case (slotE.cond)
            COND_AL: condMet = 1'b1;
            COND_EQ: condMet = flags[FLAG_Z];
            COND_NE: condMet = ~flags[FLAG_Z];
            COND_LT: condMet = flags[FLAG_N] ^ flags[FLAG_V];
            default: condMet = 1'b0;
        endcase
    end

    assign takenE   = slotE.valid & slotE.branch & condMet;
    assign redirect = slotWB.valid & takenWB;

    // A redirect squashes everything younger than the branch; killD catches the one still in D
    always_comb begin
        nextE        = ctlD;
        nextE.valid  = ctlD.valid & ~redirect & ~killD;
        nextM        = slotE;
        nextM.valid  = slotE.valid & ~redirect;
        nextWB       = slotM;
        nextWB.valid = slotM.valid & ~redirect;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slotE        <= '0;
            slotM        <= '0;
            slotWB       <= '0;
            takenM       <= 1'b0;
            takenWB      <= 1'b0;
            flags        <= '0;
            killD        <= 1'b0;
            retiredCount <= '0;
        end else begin
            slotE   <= nextE;
            slotM   <= nextM;
            slotWB  <= nextWB;
            takenM  <= takenE;
            takenWB <= takenM;
            killD   <= redirect;
            if (slotE.valid && slotE.setFlags)
                flags <= {N, Z, V, C};
            if (slotWB.valid)
                retiredCount <= retiredCount + COUNTWIDTH'(1);
        end
    end

    assign obtainPCAsR1D    = ctlD.branch;
    assign data2SelectorE   = slotE.valid & slotE.data2Sel;
    assign aluControlE      = slotE.valid ? slotE.aluCtl : ALU_ADD;
    assign writeDataEnableM = slotM.valid & slotM.memWrite;
    assign resultSelectorWB = slotWB.valid & slotWB.memToReg;
    assign writeEnableD     = slotWB.valid & slotWB.regWrite;
    assign PCSelectorF      = redirect;

    // Bundle fields that are not consumed in the later stages
    assign unusedCtl = ^{flags[FLAG_C], slotM.aluCtl, slotM.data2Sel, slotM.memToReg,
                         slotM.regWrite, slotM.branch, slotM.cond, slotM.setFlags,
                         slotWB.aluCtl, slotWB.data2Sel, slotWB.memWrite, slotWB.branch,
                         slotWB.cond, slotWB.setFlags};

endmodule
